// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-requester Wishbone arbiter (I-cache R0, D-cache R1) onto one memory bus
// with round-robin tie-break and a watchdog that aborts cycles the memory never answers.
module wb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [2:0]  CC      = 3'b000,
  parameter logic [2:0]  EOB     = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        R0_CYC,
  input  logic        R0_STB,
  input  logic        R0_WE,
  input  logic [31:0] R0_ADR,
  input  logic [31:0] R0_DAT_O,
  input  logic [2:0]  R0_CTI_O,
  output logic        R0_ACK,
  output logic        R0_ERR,
  output logic        R0_RTY,
  output logic [31:0] R0_DAT_I,
  input  logic        R1_CYC,
  input  logic        R1_STB,
  input  logic        R1_WE,
  input  logic [31:0] R1_ADR,
  input  logic [31:0] R1_DAT_O,
  input  logic [2:0]  R1_CTI_O,
  output logic        R1_ACK,
  output logic        R1_ERR,
  output logic        R1_RTY,
  output logic [31:0] R1_DAT_I,
  output logic        M_CYC,
  output logic        M_STB,
  output logic        M_WE,
  output logic [31:0] M_ADR,
  output logic [31:0] M_DAT_O,
  output logic [2:0]  M_CTI_O,
  input  logic        M_ACK,
  input  logic        M_ERR,
  input  logic        M_RTY,
  input  logic [31:0] M_DAT_I,
  output logic [1:0]  GNT
);
  localparam int unsigned W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [W-1:0] wdog_q, wdog_d;
  logic owned, sel, cyc, resp, tmo, pick;
  logic unused_eob;
  // grant release follows CYC alone, so the end-of-burst code carries no behaviour here
  assign unused_eob = ^EOB;
  // LAST always names the current (or aborted) owner, so it doubles as the bus select
  assign sel      = last_q;
  assign owned    = (state_q == GNT0) || (state_q == GNT1);
  assign cyc      = sel ? R1_CYC : R0_CYC;
  assign pick     = (R0_CYC && R1_CYC) ? ~last_q : R1_CYC;
  assign M_CYC    = owned & cyc;
  assign M_STB    = owned & (sel ? R1_STB : R0_STB);
  assign M_WE     = owned & (sel ? R1_WE : R0_WE);
  assign M_ADR    = owned ? (sel ? R1_ADR : R0_ADR) : '0;
  assign M_DAT_O  = owned ? (sel ? R1_DAT_O : R0_DAT_O) : '0;
  assign M_CTI_O  = owned ? (sel ? R1_CTI_O : R0_CTI_O) : CC;
  assign resp     = M_ACK | M_ERR | M_RTY;
  assign tmo      = M_STB & ~resp & (wdog_q == W'(TIMEOUT));
  assign R0_ACK   = owned & ~sel & M_ACK;
  assign R0_ERR   = owned & ~sel & (M_ERR | tmo);
  assign R0_RTY   = owned & ~sel & M_RTY;
  assign R1_ACK   = owned & sel & M_ACK;
  assign R1_ERR   = owned & sel & (M_ERR | tmo);
  assign R1_RTY   = owned & sel & M_RTY;
  assign R0_DAT_I = M_DAT_I;
  assign R1_DAT_I = M_DAT_I;
  assign GNT      = (state_q == IDLE) ? 2'b00 : {sel, ~sel};
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = (M_STB && !resp) ? wdog_q + 1'b1 : '0;
    if (state_q == IDLE && (R0_CYC || R1_CYC)) begin
      state_d = pick ? GNT1 : GNT0;
      last_d  = pick;
    end else if (state_q != IDLE && !cyc) state_d = IDLE;
    else if (tmo) state_d = ABORT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule
